// File: rtl/window_compare_latch.sv
// Multi-channel signed window comparator with per-condition persistence
// filters, latched fault flags and a first-fault record.
//
// Ports:
//   clk_i, rst_n_i    clock, async active-low reset
//   sample_i          sample strobe; compares and counters move only when high
//   values_i          CHANNELS signed samples, channel c at [c*WIDTH +: WIDTH]
//   limits_i          per channel {L, H}; H in the low half, L in the high half
//   filter_len_i      consecutive true samples needed to trip (0 acts as 1)
//   mask_i            trip enable per condition (index 2*c+k, k=0 over, k=1 under)
//   clear_i           clears latched faults and the first-fault record
//   compare_o         registered raw over/under results
//   fault_o           latched fault per condition
//   fault_any_o       OR of fault_o
//   first_valid_o     first_fault_o holds a valid index
//   first_fault_o     index of the condition that tripped first
module window_compare_latch #(
  parameter int WIDTH        = 16,
  parameter int CHANNELS     = 4,
  parameter int FILTER_WIDTH = 4,
  localparam int NCOND       = 2 * CHANNELS,
  localparam int IDXW        = $clog2(NCOND)
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            sample_i,
  input  logic [CHANNELS*WIDTH-1:0]       values_i,
  input  logic [CHANNELS*2*WIDTH-1:0]     limits_i,
  input  logic [FILTER_WIDTH-1:0]         filter_len_i,
  input  logic [NCOND-1:0]                mask_i,
  input  logic                            clear_i,
  output logic [NCOND-1:0]                compare_o,
  output logic [NCOND-1:0]                fault_o,
  output logic                            fault_any_o,
  output logic                            first_valid_o,
  output logic [IDXW-1:0]                 first_fault_o
);

  logic [NCOND-1:0] cond;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [WIDTH-1:0] v;
    logic signed [WIDTH-1:0] h;
    logic signed [WIDTH-1:0] l;

    assign v = values_i[c*WIDTH +: WIDTH];
    assign h = limits_i[c*2*WIDTH +: WIDTH];
    assign l = limits_i[c*2*WIDTH+WIDTH +: WIDTH];

    assign cond[2*c]   = v > h;
    assign cond[2*c+1] = v < l;
  end

  logic [NCOND-1:0]                   compare_q, compare_d;
  logic [NCOND-1:0]                   fault_q, fault_d;
  logic [NCOND-1:0][FILTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                               first_valid_q, first_valid_d;
  logic [IDXW-1:0]                    first_fault_q, first_fault_d;

  logic [FILTER_WIDTH-1:0] len_eff;
  logic [NCOND-1:0]        trip;
  logic [IDXW-1:0]         first_idx;

  // Length 0 is treated as 1 so a zero setting never disables tripping.
  assign len_eff = (filter_len_i == '0)
                 ? FILTER_WIDTH'(1) : filter_len_i;

  always_comb begin
    trip  = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < NCOND; i++) begin
      // The trip test uses the un-saturated next count, one bit wider,
      // so a saturated counter still satisfies len = all-ones.
      logic [FILTER_WIDTH:0] inc;
      inc = {1'b0, cnt_q[i]} + (FILTER_WIDTH+1)'(1);
      trip[i] = sample_i & cond[i] & mask_i[i]
              & (inc >= {1'b0, len_eff});
      if (sample_i) begin
        if (!cond[i])
          cnt_d[i] = '0;
        else if (cnt_q[i] != '1)
          cnt_d[i] = inc[FILTER_WIDTH-1:0];
      end
    end
  end

  // Lowest tripping index wins when several trip together.
  always_comb begin
    first_idx = '0;
    for (int i = NCOND - 1; i >= 0; i--) begin
      if (trip[i]) first_idx = IDXW'(i);
    end
  end

  always_comb begin
    compare_d     = sample_i ? cond : compare_q;
    fault_d       = fault_q | trip;
    first_valid_d = first_valid_q;
    first_fault_d = first_fault_q;
    if (!first_valid_q && (|trip)) begin
      first_valid_d = 1'b1;
      first_fault_d = first_idx;
    end
    // Clear outranks any trip on the same edge.
    if (clear_i) begin
      fault_d       = '0;
      first_valid_d = 1'b0;
      first_fault_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      compare_q     <= '0;
      fault_q       <= '0;
      cnt_q         <= '0;
      first_valid_q <= 1'b0;
      first_fault_q <= '0;
    end else begin
      compare_q     <= compare_d;
      fault_q       <= fault_d;
      cnt_q         <= cnt_d;
      first_valid_q <= first_valid_d;
      first_fault_q <= first_fault_d;
    end
  end

  assign compare_o     = compare_q;
  assign fault_o       = fault_q;
  assign fault_any_o   = |fault_q;
  assign first_valid_o = first_valid_q;
  assign first_fault_o = first_fault_q;

endmodule

// File: doc/window_compare_latch.md
# window_compare_latch

Multi-channel signed window comparator with a per-condition consecutive-sample filter and latched fault flags. Used in the protection path: each ADC channel is checked against a high and a low limit on every sample strobe. A condition must persist for a run-time number of samples before it trips a latched fault. The block also records which condition tripped first, so firmware can read the root cause over EMIF and then clear it.

## Interface
Parameters:
- WIDTH, 16, sample and limit width (signed, two's complement)
- CHANNELS, 4, number of monitored channels
- FILTER_WIDTH, 4, width of filter length and of each persistence counter

Ports:
- clk_i  in  1  system clock; every register is clocked on the rising edge
- rst_n_i  in  1  reset, asynchronous and active-low
- sample_i  in  1  sample strobe; comparisons and counters update only when high
- values_i  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH], signed
- limits_i  in  CHANNELS*2*WIDTH  channel c occupies [c*2*WIDTH +: 2*WIDTH]; high limit H in the low half, low limit L in the high half, both signed
- filter_len_i  in  FILTER_WIDTH  number of consecutive true samples needed to trip; 0 behaves as 1
- mask_i  in  2*CHANNELS  trip enable per condition; bit index is 2*c+k, with k=0 for over and k=1 for under
- clear_i  in  1  clears all latched faults and the first-fault record
- compare_o  out  2*CHANNELS  raw registered result; bit 2*c = value>H, bit 2*c+1 = value<L
- fault_o  out  2*CHANNELS  latched fault per condition, same bit indexing
- fault_any_o  out  1  combinational OR of fault_o
- first_valid_o  out  1  first_fault_o holds a valid index
- first_fault_o  out  $clog2(2*CHANNELS)  index of the condition that tripped first

## Operation
- On a cycle with sample_i=1, each condition i is evaluated with signed compares: over = value>H, under = value<L. Both compares are strict. If L>H, over and under can both be true.
- compare_o is updated only on sample cycles and holds its value otherwise.
- Each condition has its own counter cnt[i] of FILTER_WIDTH bits.
  - On a sample cycle where the condition is true, cnt[i] increments and saturates at all-ones.
  - On a sample cycle where the condition is false, cnt[i] goes to 0.
  - cnt[i] holds when sample_i=0.
- Trip rule: on a sample cycle, trip[i] = condition true AND (cnt[i]+1) >= max(filter_len_i,1), computed with the un-saturated next value, AND mask_i[i].
- fault_o[i] is set by trip[i] and stays set until clear_i. Counters keep running while a fault is latched.
- Masking:
  - A masked condition still counts but never trips.
  - Changing mask_i has no effect on faults that are already latched.
- First-fault record:
  - While first_valid_o=0, the first cycle with any trip loads first_fault_o with the lowest tripping index and sets first_valid_o.
  - Later trips do not change the record.
- clear_i:
  - When high, the next edge clears fault_o, first_valid_o and first_fault_o.
  - clear_i takes priority over a trip in the same cycle. Counters are not cleared.
  - A persisting condition therefore re-trips on its next sample cycle, because cnt+1 >= len still holds, and loads a new first-fault record.
- Changing filter_len_i takes effect on the next sample cycle. It never clears a fault.

## Timing
- Reset values: compare_o, fault_o, all cnt[i], first_valid_o and first_fault_o are all 0, so fault_any_o=0.
- Latency: with sample_i high at edge N, compare_o, fault_o and first_fault_o are valid after edge N. fault_any_o follows fault_o in the same cycle.
- filter_len_i=n with the condition true from sample k onward: the fault latches at sample k+n-1.
- clear_i is level-sensitive. It clears at every edge it is high, and it blocks trips for that whole time.
- Asserting rst_n_i mid-run immediately zeroes every register, with no clock required.

## Test plan
- Basic trip: CHANNELS=4, len=1, ch1 H=100, L=-100, mask all ones, ch1 value=101, one sample. Required: compare_o[2]=1, fault_o[2]=1, first_fault_o=2, first_valid_o=1. Repeat with value=100: no trip.
- Filter: len=3, ch0 value=-200 with L=-100. Samples 1-2 leave fault_o=0. Sample 3 sets fault_o[1]. An intervening sample with value=0 resets the count, so three further samples are needed.
- Simultaneous trips: ch2 over and ch0 under trip on the same sample. Required: first_fault_o=1, and fault_o bits 1 and 4 both set. A later ch3 trip leaves first_fault_o=1.
- Clear priority: clear_i is high on the same cycle as a trip. Required: fault_o=0 after that edge. With the condition still persisting, the fault re-trips on the next sample with len=4 and sets a new first record.
- Mask and saturation: FILTER_WIDTH=4, condition held true for 20 samples with mask=0. Required: no fault and cnt saturated at 15. Then set mask=1 with len=15: trips on the next sample.
- Reset mid-run: assert rst_n_i with faults latched and no clock edge. Required: all outputs read 0 immediately. After release, 0 samples must not trip.
